// File: rtl/sort_cmd_arbiter.sv
// sort_cmd_arbiter: round-robin front end for one shared insertion-sort engine.
// Optional build macro: SORT_ARB_AUTOSORT_EN (adds an automatic sort pass after
// every successful push before the push is acknowledged).
//
// Handshake: a requester raises req[i] with req_op/req_din stable and holds
// them until ack[i] pulses for one cycle (err and rd_data are valid in that
// same cycle). The requester is ignored in the idle cycle right after its ack,
// so it must drop req or re-request later. Engine commands are level signals
// that the engine edge-detects; a command is held until s_idle falls and is
// followed by a quiet gap so the engine's edge history sees a clean low.
module sort_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int TMO  = 64
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [DW*NREQ-1:0]   req_din,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [DW-1:0]        rd_data,
  output logic                 busy,
  output logic                 s_push,
  output logic                 s_pop,
  output logic                 s_clear,
  output logic                 s_sort,
  output logic [DW-1:0]        s_din,
  input  logic [DW-1:0]        s_dout,
  input  logic                 s_full,
  input  logic                 s_empty,
  input  logic                 s_idle,
  output logic [2:0]           dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TMO);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_GAP     = 3'd4,
    S_ACK     = 3'd5
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_gnt;
  logic [1:0]      r_op;
  logic [NREQ-1:0] r_mask;
  logic [WW-1:0]   r_wd;
  logic            r_gap;
  logic            r_timeout;
`ifdef SORT_ARB_AUTOSORT_EN
  logic            r_auto;
`endif

  logic [NREQ-1:0] w_req_m;
  logic            w_found;
  logic [IW-1:0]   w_gnt;
  logic            w_wd_exp;

  // Command line pattern {push, pop, clear, sort} for an op code.
  function automatic logic [3:0] f_lines(input logic [1:0] op);
    case (op)
      2'b00:   f_lines = 4'b1000;
      2'b01:   f_lines = 4'b0100;
      2'b10:   f_lines = 4'b0010;
      default: f_lines = 4'b0001;
    endcase
  endfunction

  // One-hot ack vector for a granted index.
  function automatic logic [NREQ-1:0] f_onehot(input logic [IW-1:0] idx);
    f_onehot = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
  assign w_wd_exp  = (r_wd == WW'(TMO - 1));

  // Round-robin pick: first unmasked request after the last winner, with wrap.
  always_comb begin
    w_req_m = req & ~r_mask;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && w_req_m[(int'(r_last) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = IW'((int'(r_last) + k) % NREQ);
      end
    end
  end

  // Command sequencer: grant, pre-check, assert, release, gap, ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_gnt     <= '0;
      r_op      <= '0;
      r_mask    <= '0;
      r_wd      <= '0;
      r_gap     <= 1'b0;
      r_timeout <= 1'b0;
`ifdef SORT_ARB_AUTOSORT_EN
      r_auto    <= 1'b0;
`endif
      ack       <= '0;
      err       <= 1'b0;
      rd_data   <= '0;
      s_din     <= '0;
      {s_push, s_pop, s_clear, s_sort} <= 4'b0000;
    end else begin
      ack <= '0;
      case (r_state)
        S_IDLE: begin
          r_mask <= '0;
          if (w_found && s_idle) begin
            r_gnt   <= w_gnt;
            r_op    <= req_op[2*int'(w_gnt) +: 2];
            s_din   <= req_din[DW*int'(w_gnt) +: DW];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_timeout <= 1'b0;
`ifdef SORT_ARB_AUTOSORT_EN
          r_auto    <= 1'b0;
`endif
          if ((r_op == OP_PUSH && s_full) || (r_op == OP_POP && s_empty)) begin
            err     <= 1'b1;
            ack     <= f_onehot(r_gnt);
            r_state <= S_ACK;
          end else begin
            r_wd    <= '0;
            {s_push, s_pop, s_clear, s_sort} <= f_lines(r_op);
            r_state <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          if (w_wd_exp) begin
            {s_push, s_pop, s_clear, s_sort} <= 4'b0000;
            r_timeout <= 1'b1;
            r_gap     <= 1'b0;
            r_state   <= S_GAP;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (!s_idle) begin
              {s_push, s_pop, s_clear, s_sort} <= 4'b0000;
              r_state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (w_wd_exp) begin
            r_timeout <= 1'b1;
            r_gap     <= 1'b0;
            r_state   <= S_GAP;
          end else begin
            r_wd <= r_wd + 1'b1;
            if (s_idle) begin
              r_gap   <= 1'b0;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else begin
`ifdef SORT_ARB_AUTOSORT_EN
            if (r_op == OP_PUSH && !r_timeout && !r_auto) begin
              // Successful push: run a sort pass before acknowledging.
              r_auto  <= 1'b1;
              r_wd    <= '0;
              {s_push, s_pop, s_clear, s_sort} <= 4'b0001;
              r_state <= S_ASSERT;
            end else begin
              err     <= r_timeout;
              ack     <= f_onehot(r_gnt);
              if (r_op == OP_POP) rd_data <= s_dout;
              r_state <= S_ACK;
            end
`else
            err     <= r_timeout;
            ack     <= f_onehot(r_gnt);
            if (r_op == OP_POP) rd_data <= s_dout;
            r_state <= S_ACK;
`endif
          end
        end
        S_ACK: begin
          err     <= 1'b0;
          r_last  <= r_gnt;
          r_mask  <= f_onehot(r_gnt);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_cmd_arbiter.sv
// tb_sort_cmd_arbiter: directed and randomized bench for sort_cmd_arbiter with
// a behavioural insertion-sort engine stub and a queue-based reference model.
module tb_sort_cmd_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int TMO   = 64;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req = '0;
  logic [2*NREQ-1:0]  req_op = '0;
  logic [DW*NREQ-1:0] req_din = '0;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [DW-1:0]      rd_data;
  logic               busy;
  logic               s_push, s_pop, s_clear, s_sort;
  logic [DW-1:0]      s_din;
  logic [DW-1:0]      s_dout;
  logic               s_full, s_empty, s_idle;
  logic [2:0]         dbg_state;

  sort_cmd_arbiter #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .req(req), .req_op(req_op), .req_din(req_din),
    .ack(ack), .err(err), .rd_data(rd_data), .busy(busy),
    .s_push(s_push), .s_pop(s_pop), .s_clear(s_clear), .s_sort(s_sort),
    .s_din(s_din), .s_dout(s_dout),
    .s_full(s_full), .s_empty(s_empty), .s_idle(s_idle),
    .dbg_state(dbg_state)
  );

  // ---------------- engine stub ----------------
  logic [DW-1:0] eng_q[$];
  int            e_count = 0;
  logic          e_busy = 1'b0;
  int            e_cnt = 0;
  logic [1:0]    e_op = 2'b00;
  logic [DW-1:0] e_data = '0;
  logic [DW-1:0] e_dout = '0;
  logic          p_push = 1'b0, p_pop = 1'b0, p_clear = 1'b0, p_sort = 1'b0;
  bit            stuck = 1'b0;
  bit            force_full = 1'b0;
  int            e_lat_lo = 1, e_lat_hi = 4, e_sort_x = 6;

  assign s_idle  = ~e_busy;
  assign s_full  = force_full || (e_count >= DEPTH);
  assign s_empty = (e_count == 0);
  assign s_dout  = e_dout;

  always @(posedge clk) begin
    p_push  <= s_push;
    p_pop   <= s_pop;
    p_clear <= s_clear;
    p_sort  <= s_sort;
    if (e_busy) begin
      if (e_cnt <= 1) begin
        e_busy <= 1'b0;
        case (e_op)
          2'b00: if (eng_q.size() < DEPTH) begin
                   eng_q.push_back(e_data);
                   e_count <= e_count + 1;
                 end
          2'b01: if (eng_q.size() > 0) begin
                   e_dout <= eng_q[0];
                   void'(eng_q.pop_front());
                   e_count <= e_count - 1;
                 end
          2'b10: begin eng_q.delete(); e_count <= 0; end
          default: eng_q.rsort();
        endcase
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end else if (!stuck) begin
      if (s_push && !p_push) begin
        e_busy <= 1'b1; e_op <= 2'b00; e_data <= s_din;
        e_cnt <= $urandom_range(e_lat_hi, e_lat_lo);
      end else if (s_pop && !p_pop) begin
        e_busy <= 1'b1; e_op <= 2'b01;
        e_cnt <= $urandom_range(e_lat_hi, e_lat_lo);
      end else if (s_clear && !p_clear) begin
        e_busy <= 1'b1; e_op <= 2'b10;
        e_cnt <= $urandom_range(e_lat_hi, e_lat_lo);
      end else if (s_sort && !p_sort) begin
        e_busy <= 1'b1; e_op <= 2'b11;
        e_cnt <= $urandom_range(e_lat_hi, e_lat_lo) + $urandom_range(e_sort_x, 0);
      end
    end
  end

  // Line activity monitor: cycles with s_push high, s_pop rising edges.
  int n_push_hi = 0;
  int n_pop_edge = 0;
  always @(posedge clk) begin
    if (s_push) n_push_hi <= n_push_hi + 1;
    if (s_pop && !p_pop) n_pop_edge <= n_pop_edge + 1;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_rd = '0;
  int            m_last = NREQ - 1;
  logic [1:0]    t_op[NREQ];
  logic [DW-1:0] t_din[NREQ];
  logic [23:0]   ord_v = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = pending requester closest after the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
    int best, bd, d;
    best = -1;
    bd = NREQ + 1;
    for (int r = 0; r < NREQ; r++) begin
      if (p[r]) begin
        d = (r - last - 1 + 2 * NREQ) % NREQ;
        if (d < bd) begin bd = d; best = r; end
      end
    end
    return best;
  endfunction

  // Expected effect of one command on the array; returns expected err.
  task automatic model_apply(input logic [1:0] op, input logic [DW-1:0] din, output logic e_err);
    e_err = 1'b0;
    if (stuck) begin
      e_err = 1'b1;
    end else begin
      case (op)
        2'b00: if (force_full || m_q.size() >= DEPTH) e_err = 1'b1;
               else begin
                 m_q.push_back(din);
`ifdef SORT_ARB_AUTOSORT_EN
                 m_q.rsort();
`endif
               end
        2'b01: if (m_q.size() == 0) e_err = 1'b1;
               else m_rd = m_q.pop_front();
        2'b10: m_q.delete();
        default: m_q.rsort();
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Raise all requesters in 'set'; each in 'rearm' re-requests once after its ack.
  task automatic serve(input logic [NREQ-1:0] set, input logic [NREQ-1:0] rearm_in);
    logic [NREQ-1:0] pend, rearm, raise_next, exp_ack;
    logic            e_err;
    int              cyc, w, a_idx;
    pend = set;
    rearm = rearm_in;
    raise_next = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (set[r]) begin
        req_op[2*r +: 2]   = t_op[r];
        req_din[DW*r +: DW] = t_din[r];
      end
    end
    req = req | set;
    cyc = 0;
    while ((pend != '0 || raise_next != '0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (raise_next != '0) begin
        req = req | raise_next;
        pend = pend | raise_next;
        raise_next = '0;
      end
      if (ack != '0) begin
        a_idx = 0;
        for (int r = NREQ - 1; r >= 0; r--) if (ack[r]) a_idx = r;
        ord_v = {ord_v[19:0], 4'(a_idx)};
        w = rr_pick(pend, m_last);
        if (w < 0) begin
          check("spurious_ack", 32'(ack), 32'd0);
        end else begin
          exp_ack = '0;
          exp_ack[w] = 1'b1;
          check("ack_grant", 32'(ack), 32'(exp_ack));
          model_apply(t_op[w], t_din[w], e_err);
          check("err", 32'(err), 32'(e_err));
          check("rd_data", 32'(rd_data), 32'(m_rd));
          m_last = w;
          req[w] = 1'b0;
          pend[w] = 1'b0;
          if (rearm[w]) begin
            rearm[w] = 1'b0;
            raise_next[w] = 1'b1;
          end
        end
      end
    end
    if (pend != '0) check("serve_timeout", 32'(pend), 32'd0);
    @(negedge clk);
    check("ack_single_cycle", 32'(ack), 32'd0);
  endtask

  task automatic one(input int r, input logic [1:0] op, input logic [DW-1:0] din);
    logic [NREQ-1:0] s;
    t_op[r] = op;
    t_din[r] = din;
    s = '0;
    s[r] = 1'b1;
    serve(s, '0);
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    req = '0;
    m_last = NREQ - 1;
    m_rd = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int snap, cyc, sel;
    logic [NREQ-1:0] set;
    for (int r = 0; r < NREQ; r++) begin t_op[r] = 2'b00; t_din[r] = '0; end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lines", 32'({s_push, s_pop, s_clear, s_sort}), 32'd0);
    check("rst_s_din", 32'(s_din), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single push from requester 0
    snap = n_push_hi;
    one(0, 2'b00, 16'h0005);
    check("push_hi_cycles", 32'(n_push_hi - snap), 32'd2);
    check("engine_count_1", 32'(e_count), 32'd1);
    check("lines_low_after", 32'({s_push, s_pop, s_clear, s_sort}), 32'd0);

    // Simultaneous requests from reset, 0 and 1 re-request after their acks
    one(0, 2'b10, '0);
    reset_pulse();
    for (int r = 0; r < NREQ; r++) begin t_op[r] = 2'b00; t_din[r] = DW'(16'h0100 + r); end
    ord_v = '0;
    serve(4'b1111, 4'b0011);
    check("grant_order", 32'(ord_v), 32'h012301);

    // Pop on empty, then push 3,1,2, sort, pop x3
    one(2, 2'b10, '0);
    snap = n_pop_edge;
    one(3, 2'b01, '0);
    check("empty_pop_no_edge", 32'(n_pop_edge - snap), 32'd0);
    one(1, 2'b00, 16'h0003);
    one(2, 2'b00, 16'h0001);
    one(3, 2'b00, 16'h0002);
    one(0, 2'b11, '0);
    one(1, 2'b01, '0);
    check("pop_1st", 32'(rd_data), 32'h0003);
    one(1, 2'b01, '0);
    check("pop_2nd", 32'(rd_data), 32'h0002);
    one(1, 2'b01, '0);
    check("pop_3rd", 32'(rd_data), 32'h0001);

    // Push rejected while full
    force_full = 1'b1;
    snap = n_push_hi;
    one(2, 2'b00, 16'h00AA);
    check("full_no_push", 32'(n_push_hi - snap), 32'd0);
    force_full = 1'b0;

    // Watchdog: engine never starts
    stuck = 1'b1;
    snap = n_push_hi;
    one(3, 2'b00, 16'h0077);
    check("tmo_push_cycles", 32'(n_push_hi - snap), 32'(TMO));
    check("tmo_lines_low", 32'({s_push, s_pop, s_clear, s_sort}), 32'd0);
    stuck = 1'b0;
    one(0, 2'b00, 16'h0011);

    // Reset during S_RELEASE of a sort
    e_lat_lo = 20; e_lat_hi = 20; e_sort_x = 0;
    t_op[0] = 2'b11;
    req_op[1:0] = 2'b11;
    req[0] = 1'b1;
    cyc = 0;
    while (!s_sort && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_mid_sort_seen", 32'(s_sort), 32'd1);
    cyc = 0;
    while (s_sort && cyc < 50) begin @(negedge clk); cyc++; end
    check("rst_mid_released", 32'({s_sort, busy}), 32'b01);
    rstn = 1'b0;
    req[0] = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_lines", 32'({s_push, s_pop, s_clear, s_sort, err}), 32'd0);
    m_q.rsort();
    m_last = NREQ - 1;
    m_rd = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    t_op[1] = 2'b00;
    t_din[1] = 16'h0042;
    req_op[3:2] = 2'b00;
    req_din[DW +: DW] = 16'h0042;
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("no_grant_engine_busy", 32'(busy), 32'd0);
    serve(4'b0010, '0);
    e_lat_lo = 1; e_lat_hi = 4; e_sort_x = 6;

    // Push 9,4,7 then pop x3
    one(2, 2'b10, '0);
    one(0, 2'b00, 16'h0009);
    one(1, 2'b00, 16'h0004);
    one(2, 2'b00, 16'h0007);
    one(3, 2'b01, '0);
    check("seq_pop_1", 32'(rd_data), 32'h0009);
    one(3, 2'b01, '0);
`ifdef SORT_ARB_AUTOSORT_EN
    check("seq_pop_2", 32'(rd_data), 32'h0007);
`else
    check("seq_pop_2", 32'(rd_data), 32'h0004);
`endif
    one(3, 2'b01, '0);
`ifdef SORT_ARB_AUTOSORT_EN
    check("seq_pop_3", 32'(rd_data), 32'h0004);
`else
    check("seq_pop_3", 32'(rd_data), 32'h0007);
`endif

    // Randomized concurrent rounds against the model
    for (int rnd = 0; rnd < 30; rnd++) begin
      set = NREQ'($urandom_range((1 << NREQ) - 1, 1));
      for (int r = 0; r < NREQ; r++) begin
        sel = $urandom_range(99, 0);
        t_op[r]  = (sel < 50) ? 2'b00 : (sel < 80) ? 2'b01 : (sel < 85) ? 2'b10 : 2'b11;
        t_din[r] = DW'($urandom);
      end
      serve(set, '0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    check("final_count", 32'(e_count), 32'(m_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_cmd_arbiter.md
Name: sort_cmd_arbiter

Overview:
- Shares one insertion-sort engine among NREQ requesters.
- The engine accepts push/pop/clear/sort as rising-edge level commands and reports an idle flag.
- This block arbitrates requests round-robin and pre-checks full/empty.
- It generates correctly timed command levels for the engine, waits for completion, and returns an ack, an error flag and pop data to the winning requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, data width.
- TMO, 64, watchdog limit in cycles per command (>=8).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_op  in  2*NREQ  per-requester op: 00 push, 01 pop, 10 clear, 11 sort
- req_din  in  DW*NREQ  per-requester push data
- ack  out  NREQ  one-cycle completion pulse, one-hot
- err  out  1  valid with ack: rejected or timed out
- rd_data  out  DW  pop result, valid with ack
- busy  out  1  high whenever state != S_IDLE
- s_push, s_pop, s_clear, s_sort  out  1 each  engine command levels
- s_din  out  DW  engine push data
- s_dout  in  DW  engine pop data
- s_full, s_empty, s_idle  in  1 each  engine status

Behaviour:
- Reset: all outputs 0, state S_IDLE, round-robin pointer last=NREQ-1 so requester 0 wins first, watchdog=0.
- Requester rule: hold req/op/din stable until ack. A requester is masked in the S_IDLE cycle immediately after its ack, so it must drop req or re-request later.
- S_IDLE: if any unmasked req and s_idle=1, grant g = first set bit searching from last+1 with wrap. Latch g, op and din; s_din <= din_g. Go to S_CHECK.
- S_CHECK: the following go to S_ACK with err=1 and issue no engine command:
  - push with s_full=1
  - pop with s_empty=1
  - Otherwise go to S_ASSERT; watchdog cleared.
- S_ASSERT: drive the op's s_* line high, all others low. Stay until s_idle=0 (engine started), then go to S_RELEASE.
- S_RELEASE: all s_* low. Stay until s_idle=1, then go to S_GAP.
- S_GAP: two cycles with all lines low, so the engine's edge-detect history clears. Go to S_ACK.
- S_ACK: ack[g]=1 for exactly one cycle; err as decided; last <= g.
  - On pop: rd_data <= s_dout, captured on the S_GAP->S_ACK edge; rd_data holds until the next pop.
  - Next state S_IDLE.
- Watchdog: counts cycles in S_ASSERT+S_RELEASE. On reaching TMO, drop all lines and go to S_GAP, then S_ACK with err=1.
- Sort: the engine may stay non-idle for many cycles; it is bounded only by TMO. TMO must cover the worst-case sort; the integrator sizes it.
- Only one command is in flight at any time. Requests arriving while busy wait; no queueing beyond the req levels.
- Simultaneous requests: resolved only by the rotating pointer. No starvation; any waiting requester is served within NREQ grants.
- s_idle=0 in S_IDLE (engine externally busy): no grant.
- Reset mid-command: all lines drop immediately and ack is not produced. The requester must retry.

Optional Feature:
- Macro SORT_ARB_AUTOSORT_EN.
- Defined: after a successful push (not rejected, no timeout), S_GAP goes to an internal sort sequence (S_ASSERT/S_RELEASE/S_GAP with s_sort) before S_ACK. The array therefore stays sorted after each push; err reflects a timeout in either phase.
- Undefined: push acks directly after its own S_GAP; sort occurs only on op 11.

Test Plan:
- Reset, single requester 0 pushes 16'h0005: s_push high until s_idle drops, then low; ack[0] pulses once, err=0; engine count 1.
- Requesters 0..3 all request push simultaneously from reset: grants/acks in order 0,1,2,3. Requester 1 re-requests after its ack and 0 re-requests: next order 2,3 already served, then 0 before 1 per pointer.
- Pop on empty engine: ack with err=1, no s_pop edge observed. Push 3, 1, 2, sort, pop three times: rd_data 16'h0003, 16'h0002, 16'h0001.
- Push with s_full=1 held: err=1, s_push never asserted.
- Engine with s_idle forced high (never starts): watchdog expires at TMO=64; ack with err=1; all s_* low; the next request is served normally.
- Assert rstn low during S_RELEASE of a sort: outputs 0 within reset; after release, a new push completes with err=0.
- With SORT_ARB_AUTOSORT_EN: push 9, 4, 7 then pop x3: rd_data 9, 7, 4.
